// File: rtl/sinogram_line_fetcher_pkg.sv
// Shared constants and state encoding for the sinogram line fetcher.
package sinogram_line_fetcher_pkg;

    localparam int NABP_PROJ_LINE_SIZE = 256;
    localparam int NABP_ANGLE_LEN      = 9;

    localparam int FETCH_LINE_SIZE   = NABP_PROJ_LINE_SIZE;
    localparam int FETCH_S_WIDTH     = $clog2(FETCH_LINE_SIZE);
    localparam int FETCH_ANGLE_WIDTH = NABP_ANGLE_LEN;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_FILL,
        ST_DRAIN,
        ST_FINISH
    } fetch_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sinogram_line_fetcher_sg_latency_pipe.sv
// Valid + address delay line matching the sinogram RAM read latency.
module sg_latency_pipe #(
    parameter int STAGES = 1,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_vld,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_vld,
    output logic [ADDR_W-1:0] out_addr
);

    logic [STAGES-1:0] vld_p;
    logic [ADDR_W-1:0] addr_p [STAGES];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= in_vld;
            for (int i = STAGES - 1; i > 0; i--) vld_p[i] <= vld_p[i-1];
        end
    end

    // Address stages carry no reset; they are qualified by vld_p.
    always_ff @(posedge clk) begin
        addr_p[0] <= in_addr;
        for (int i = STAGES - 1; i > 0; i--) addr_p[i] <= addr_p[i-1];
    end

    assign out_vld  = vld_p[STAGES-1];
    assign out_addr = addr_p[STAGES-1];

endmodule

// File: rtl/sinogram_line_fetcher.sv
// Fetches one projection line per angle into a ping-pong line buffer.
// Optional statistics outputs are enabled with NABP_FETCH_STATS_EN.
module sinogram_line_fetcher
    import sinogram_line_fetcher_pkg::*;
#(
    parameter int LINE_SIZE   = FETCH_LINE_SIZE,
    parameter int S_WIDTH     = $clog2(LINE_SIZE),
    parameter int ANGLE_WIDTH = FETCH_ANGLE_WIDTH,
    parameter int DATA_WIDTH  = 12,
    parameter int SG_LATENCY  = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    output logic                   fr_next_angle,
    input  logic [ANGLE_WIDTH-1:0] fr_angle,
    input  logic                   fr_has_next_angle,
    input  logic                   fr_next_angle_ack,
    output logic [S_WIDTH-1:0]     fr_s_val,
    input  logic [DATA_WIDTH-1:0]  sg_data,
    output logic                   buf_we,
    output logic                   buf_bank,
    output logic [S_WIDTH-1:0]     buf_addr,
    output logic [DATA_WIDTH-1:0]  buf_wdata,
    output logic                   pe_line_valid,
    output logic                   pe_line_bank,
    output logic [ANGLE_WIDTH-1:0] pe_line_angle,
    input  logic                   pe_line_taken,
`ifdef NABP_FETCH_STATS_EN
    output logic [15:0]            stat_lines,
    output logic [15:0]            stat_stall,
`endif
    output logic                   done
);

    fetch_state_t state, state_nxt;

    logic [1:0]             full;
    logic                   fill_ptr;
    logic                   rd_ptr;
    logic [S_WIDTH-1:0]     s_cnt;
    logic [2:0]             drain_cnt;
    logic [ANGLE_WIDTH-1:0] angle_reg [2];

    logic               last_s;
    logic               drain_end;
    logic               take;
    logic [1:0]         set_mask;
    logic [1:0]         clr_mask;
    logic               pipe_vld;
    logic [S_WIDTH-1:0] pipe_addr;

    assign last_s    = (s_cnt == S_WIDTH'(LINE_SIZE - 1));
    assign drain_end = (state == ST_DRAIN) && (drain_cnt == 3'(SG_LATENCY - 1));
    assign take      = pe_line_taken && full[rd_ptr];
    assign set_mask  = drain_end ? (2'b01 << fill_ptr) : 2'b00;
    assign clr_mask  = take ? (2'b01 << rd_ptr) : 2'b00;

    always_comb begin
        state_nxt     = state;
        fr_next_angle = 1'b0;
        done          = 1'b0;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_REQ;
            ST_REQ: begin
                fr_next_angle = !full[fill_ptr];
                if (!full[fill_ptr] && fr_next_angle_ack)      state_nxt = ST_FILL;
                else if (!full[fill_ptr] && !fr_has_next_angle) state_nxt = ST_FINISH;
            end
            ST_FILL:  if (last_s) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_end) state_nxt = ST_REQ;
            ST_FINISH: begin
                if (full == 2'b00) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bank set (end of drain) and release (take) never hit the same bank.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            full      <= 2'b00;
            fill_ptr  <= 1'b0;
            rd_ptr    <= 1'b0;
            s_cnt     <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            full      <= (full & ~clr_mask) | set_mask;
            fill_ptr  <= fill_ptr ^ drain_end;
            rd_ptr    <= rd_ptr ^ take;
            s_cnt     <= (state == ST_FILL && !last_s) ? s_cnt + S_WIDTH'(1) : '0;
            drain_cnt <= (state == ST_DRAIN && !drain_end) ? drain_cnt + 3'd1 : 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_FILL && s_cnt == '0) angle_reg[fill_ptr] <= fr_angle;
    end

    sg_latency_pipe #(
        .STAGES (SG_LATENCY),
        .ADDR_W (S_WIDTH)
    ) u_sg_latency_pipe (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_vld   (state == ST_FILL),
        .in_addr  (s_cnt),
        .out_vld  (pipe_vld),
        .out_addr (pipe_addr)
    );

    assign fr_s_val      = s_cnt;
    assign buf_we        = pipe_vld;
    assign buf_bank      = fill_ptr;
    assign buf_addr      = pipe_vld ? pipe_addr : '0;
    assign buf_wdata     = pipe_vld ? sg_data : '0;
    assign pe_line_valid = full[rd_ptr];
    assign pe_line_bank  = rd_ptr;
    assign pe_line_angle = full[rd_ptr] ? angle_reg[rd_ptr] : '0;

`ifdef NABP_FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n || (state == ST_IDLE && start)) begin
            stat_lines <= 16'd0;
            stat_stall <= 16'd0;
        end else begin
            if (drain_end) stat_lines <= sat_inc16(stat_lines);
            if (state == ST_REQ && full[fill_ptr]) stat_stall <= sat_inc16(stat_stall);
        end
    end
`endif

endmodule

// File: tb/tb_sinogram_line_fetcher.sv
// Directed bench: LINE_SIZE=8, latency 1 and latency 3 instances, model addresser.
module tb_sinogram_line_fetcher;

    localparam int LS = 8;
    localparam int SW = 3;
    localparam int AW = 9;
    localparam int DW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, start, taken, start_b, taken_b;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance A signals (SG_LATENCY=1)
    logic          fr_next_angle, has_next, ack;
    logic [AW-1:0] fr_angle = '0;
    logic [SW-1:0] s_val;
    logic [DW-1:0] sg_data = '0;
    logic          buf_we, buf_bank, pe_valid, pe_bank, done;
    logic [SW-1:0] buf_addr;
    logic [DW-1:0] buf_wdata;
    logic [AW-1:0] pe_angle;
    int            acnt = 0;

    // Instance B signals (SG_LATENCY=3)
    logic          fr_next_angle_b, has_next_b, ack_b;
    logic [AW-1:0] fr_angle_b = '0;
    logic [SW-1:0] s_val_b;
    logic [DW-1:0] sgq_b [3];
    logic          buf_we_b, buf_bank_b, pe_valid_b, pe_bank_b, done_b;
    logic [SW-1:0] buf_addr_b;
    logic [DW-1:0] buf_wdata_b;
    logic [AW-1:0] pe_angle_b;
    int            acnt_b = 0;

    sinogram_line_fetcher #(.LINE_SIZE(LS), .S_WIDTH(SW), .ANGLE_WIDTH(AW),
                            .DATA_WIDTH(DW), .SG_LATENCY(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .fr_next_angle(fr_next_angle), .fr_angle(fr_angle),
        .fr_has_next_angle(has_next), .fr_next_angle_ack(ack),
        .fr_s_val(s_val), .sg_data(sg_data),
        .buf_we(buf_we), .buf_bank(buf_bank), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .pe_line_valid(pe_valid), .pe_line_bank(pe_bank), .pe_line_angle(pe_angle),
        .pe_line_taken(taken), .done(done)
    );

    sinogram_line_fetcher #(.LINE_SIZE(LS), .S_WIDTH(SW), .ANGLE_WIDTH(AW),
                            .DATA_WIDTH(DW), .SG_LATENCY(3)) u_dut_lat3 (
        .clk(clk), .reset_n(reset_n), .start(start_b),
        .fr_next_angle(fr_next_angle_b), .fr_angle(fr_angle_b),
        .fr_has_next_angle(has_next_b), .fr_next_angle_ack(ack_b),
        .fr_s_val(s_val_b), .sg_data(sgq_b[2]),
        .buf_we(buf_we_b), .buf_bank(buf_bank_b), .buf_addr(buf_addr_b), .buf_wdata(buf_wdata_b),
        .pe_line_valid(pe_valid_b), .pe_line_bank(pe_bank_b), .pe_line_angle(pe_angle_b),
        .pe_line_taken(taken_b), .done(done_b)
    );

    // Model addresser: angles 0..2, step 1; sample = tag | s
    assign has_next   = (acnt < 3);
    assign ack        = fr_next_angle && has_next;
    assign has_next_b = (acnt_b < 3);
    assign ack_b      = fr_next_angle_b && has_next_b;

    always @(posedge clk) begin
        if (!reset_n) acnt <= 0;
        else if (ack) begin
            fr_angle <= AW'(acnt);
            acnt     <= acnt + 1;
        end
        sg_data <= 12'h500 | {9'd0, s_val};
        if (!reset_n) acnt_b <= 0;
        else if (ack_b) begin
            fr_angle_b <= AW'(acnt_b);
            acnt_b     <= acnt_b + 1;
        end
        sgq_b[0] <= 12'h300 | {9'd0, s_val_b};
        sgq_b[1] <= sgq_b[0];
        sgq_b[2] <= sgq_b[1];
    end

    // Event logs sampled on the falling edge
    int            wn = 0, an = 0, vn = 0, dn = 0, wn_b = 0;
    int            w_cyc [256];
    logic [SW-1:0] w_addr [256];
    logic          w_bank [256];
    logic [DW-1:0] w_data [256];
    int            v_cyc [32];
    int            w_cyc_b [64];
    logic [SW-1:0] w_addr_b [64];
    logic          w_bank_b [64];
    logic [DW-1:0] w_data_b [64];
    logic          pv = 1'b0;

    always @(negedge clk) begin
        if (buf_we && wn < 256) begin
            w_cyc[wn] <= cyc; w_addr[wn] <= buf_addr;
            w_bank[wn] <= buf_bank; w_data[wn] <= buf_wdata;
            wn <= wn + 1;
        end
        if (ack) an <= an + 1;
        if (pe_valid && !pv && vn < 32) begin
            v_cyc[vn] <= cyc;
            vn <= vn + 1;
        end
        pv <= pe_valid;
        if (done) dn <= dn + 1;
        if (buf_we_b && wn_b < 64) begin
            w_cyc_b[wn_b] <= cyc; w_addr_b[wn_b] <= buf_addr_b;
            w_bank_b[wn_b] <= buf_bank_b; w_data_b[wn_b] <= buf_wdata_b;
            wn_b <= wn_b + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int wb, ab, vb, db, cs, cs2, wk, k;
        reset_n = 1'b0; start = 1'b0; taken = 1'b0; start_b = 1'b0; taken_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctl", {28'd0, fr_next_angle, s_val}, 32'd0);
        check("rst_buf", {15'd0, buf_we, buf_bank, buf_addr, buf_wdata}, 32'd0);
        check("rst_pe",  {20'd0, pe_valid, pe_bank, pe_angle, done}, 32'd0);
        check("rst_b",   {11'd0, fr_next_angle_b, buf_we_b, pe_valid_b, done_b, buf_wdata_b, s_val_b, buf_addr_b}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Test 1: single line, ack at cs+1, writes cs+3..cs+10, valid at cs+11
        wb = wn; ab = an; vb = vn; db = dn;
        cs = cyc; start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        while (!pe_valid && k < 40) begin @(negedge clk); k++; end
        check("t1_valid", 32'(pe_valid), 32'd1);
        check("t1_bank", 32'(pe_bank), 32'd0);
        check("t1_angle", 32'(pe_angle), 32'd0);
        @(negedge clk);
        check("t1_valid_cyc", v_cyc[vb], cs + 11);
        for (int i = 0; i < LS; i++) begin
            check("t1_wcyc", w_cyc[wb+i], cs + 3 + i);
            check("t1_waddr", 32'(w_addr[wb+i]), i);
            check("t1_wdata", 32'(w_data[wb+i]), 32'h500 | i);
            check("t1_wbank", 32'(w_bank[wb+i]), 32'd0);
        end

        // Test 2: no take -> both banks fill, request stalls; one take -> refill bank 0
        k = 0;
        while (wn < wb + 16 && k < 60) begin @(negedge clk); k++; end
        repeat (20) @(negedge clk);
        check("t2_acks", an - ab, 2);
        check("t2_stall_req", 32'(fr_next_angle), 32'd0);
        check("t2_writes", wn - wb, 16);
        for (int i = 0; i < LS; i++) begin
            check("t2_b1_addr", 32'(w_addr[wb+8+i]), i);
            check("t2_b1_bank", 32'(w_bank[wb+8+i]), 32'd1);
        end
        check("t2_pe", {22'd0, pe_valid, pe_bank, 8'd0} | 32'(pe_angle), 32'h200);
        taken = 1'b1;
        @(negedge clk); taken = 1'b0;
        check("t2_rereq", 32'(fr_next_angle), 32'd1);
        check("t2_pe_bank1", 32'(pe_bank), 32'd1);
        check("t2_pe_angle1", 32'(pe_angle), 32'd1);
        k = 0;
        while (wn < wb + 24 && k < 40) begin @(negedge clk); k++; end
        @(negedge clk);
        check("t2_refill_bank", 32'(w_bank[wb+16]), 32'd0);
        check("t2_refill_a0", 32'(w_addr[wb+16]), 32'd0);
        check("t2_refill_a7", 32'(w_addr[wb+23]), 32'd7);

        // Test 3: take the remaining banks; done exactly once after the third take
        taken = 1'b1;
        @(negedge clk); taken = 1'b0;
        check("t3_pe_valid", 32'(pe_valid), 32'd1);
        check("t3_pe_bank", 32'(pe_bank), 32'd0);
        check("t3_pe_angle", 32'(pe_angle), 32'd2);
        check("t3_no_done_yet", dn - db, 0);
        taken = 1'b1;
        @(negedge clk); taken = 1'b0;
        check("t3_done", 32'(done), 32'd1);
        repeat (5) @(negedge clk);
        check("t3_done_once", dn - db, 1);
        check("t3_acks", an - ab, 3);
        check("t3_idle_req", 32'(fr_next_angle), 32'd0);

        // Test 4: take bank 0 on the cycle bank 1 completes
        reset_n = 1'b0; @(negedge clk); reset_n = 1'b1; @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        k = 0;
        while (!(buf_we && buf_bank && buf_addr == 3'd7) && k < 60) begin @(negedge clk); k++; end
        check("t4_found_last", 32'(buf_we), 32'd1);
        check("t4_pre_bank", 32'(pe_bank), 32'd0);
        taken = 1'b1;
        @(negedge clk); taken = 1'b0;
        check("t4_valid", 32'(pe_valid), 32'd1);
        check("t4_bank", 32'(pe_bank), 32'd1);
        check("t4_angle", 32'(pe_angle), 32'd1);
        check("t4_req_bank0_free", 32'(fr_next_angle), 32'd1);

        // Test 5: reset during FILL at s=4, then restart from s=0
        reset_n = 1'b0; @(negedge clk); reset_n = 1'b1; @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        k = 0;
        while (s_val != 3'd4 && k < 20) begin @(negedge clk); k++; end
        check("t5_at_s4", 32'(s_val), 32'd4);
        reset_n = 1'b0;
        @(negedge clk);
        check("t5_rst_ctl", {28'd0, fr_next_angle, s_val}, 32'd0);
        check("t5_rst_buf", {15'd0, buf_we, buf_bank, buf_addr, buf_wdata}, 32'd0);
        check("t5_rst_pe",  {20'd0, pe_valid, pe_bank, pe_angle, done}, 32'd0);
        reset_n = 1'b1;
        wk = wn;
        repeat (10) @(negedge clk);
        check("t5_no_writes", wn - wk, 0);
        start = 1'b1; @(negedge clk); start = 1'b0;
        @(negedge clk);
        check("t5_s0", 32'(s_val), 32'd0);
        k = 0;
        while (wn == wk && k < 10) begin @(negedge clk); k++; end
        @(negedge clk);
        check("t5_first_addr", 32'(w_addr[wk]), 32'd0);
        check("t5_first_bank", 32'(w_bank[wk]), 32'd0);

        // Test 6: latency 3, ack at cs2+1, writes cs2+5..cs2+12, next bank from cs2+17
        cs2 = cyc; start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        k = 0;
        while (wn_b < 16 && k < 80) begin @(negedge clk); k++; end
        repeat (10) @(negedge clk);
        check("t6_writes", wn_b, 16);
        check("t6_first_cyc", w_cyc_b[0], cs2 + 5);
        check("t6_last_b0_cyc", w_cyc_b[7], cs2 + 12);
        check("t6_b1_first_cyc", w_cyc_b[8], cs2 + 17);
        for (int i = 0; i < LS; i++) begin
            check("t6_addr", 32'(w_addr_b[i]), i);
            check("t6_bank", 32'(w_bank_b[i]), 32'd0);
            check("t6_data", 32'(w_data_b[i]), 32'h300 | i);
        end
        check("t6_b1_bank", 32'(w_bank_b[8]), 32'd1);
        check("t6_b1_addr0", 32'(w_addr_b[8]), 32'd0);
        check("t6_pe", {29'd0, pe_valid_b, pe_bank_b, fr_next_angle_b}, 32'b100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
